// File: rtl/posit_result_fifo_if.sv
// Result handshake bundle between posit_mul, the result FIFO and its consumer.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface posit_result_fifo_if #(
    parameter int N = 36
) ();
    logic [N-1:0] in_data;
    logic         in_done;
    logic [N-1:0] out_data;
    logic         out_zero;
    logic         out_nar;
    logic         out_sign;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  in_data, in_done, out_ready,
        output out_data, out_zero, out_nar, out_sign, out_valid
    );

    modport master (
        output in_data, in_done, out_ready,
        input  out_data, out_zero, out_nar, out_sign, out_valid
    );
endinterface

// File: rtl/posit_result_fifo.sv
// First-word-fall-through result buffer behind posit_mul, with per-entry zero/NaR/sign
// classification and saturating drop/NaR statistics.
module posit_result_fifo #(
    parameter int N     = 36,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    posit_result_fifo_if.slave       bus,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [CNT_W-1:0]         nar_cnt,
    output logic                     overflow,
    input  logic                     clr_stats
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = N + 3;

    // Entry layout: {zero, nar, sign, word}
    function automatic logic [EW-1:0] classify(input logic [N-1:0] d);
        logic z, n, s;
        z = ~|d;
        n = d[N-1] & ~|d[N-2:0];
        s = d[N-1] & ~n;
        return {z, n, s, d};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [EW-1:0]    r_last;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_nar_cnt;
    logic             r_overflow;

    logic             w_nonempty;
    logic             w_full;
    logic             w_rd;
    logic             w_wr;
    logic             w_drop;
    logic [EW-1:0]    w_entry;
    logic [EW-1:0]    w_head;
    logic [EW-1:0]    w_out;

    assign w_nonempty = (r_level != '0);
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_rd       = w_nonempty & bus.out_ready;
    assign w_wr       = bus.in_done & (~w_full | w_rd);
    assign w_drop     = bus.in_done & ~w_wr;
    assign w_entry    = classify(bus.in_data);
    assign w_head     = r_mem[r_rd_ptr];
    // While empty the outputs replay the last word handed to the consumer
    assign w_out      = w_nonempty ? w_head : r_last;

    assign bus.out_data  = w_out[N-1:0];
    assign bus.out_sign  = w_out[N];
    assign bus.out_nar   = w_out[N+1];
    assign bus.out_zero  = w_out[N+2];
    assign bus.out_valid = w_nonempty;

    assign full     = w_full;
    assign empty    = ~w_nonempty;
    assign level    = r_level;
    assign drop_cnt = r_drop_cnt;
    assign nar_cnt  = r_nar_cnt;
    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_last   <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_last   <= w_head;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // A clear on the same edge as an event discards that event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
            r_nar_cnt  <= '0;
            r_overflow <= 1'b0;
        end else if (clr_stats) begin
            r_drop_cnt <= '0;
            r_nar_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
                r_overflow <= 1'b1;
            end
            if (w_wr && w_entry[N+1]) r_nar_cnt <= sat_inc(r_nar_cnt);
        end
    end
endmodule

// File: tb/tb_posit_result_fifo.sv
// Scoreboard bench for posit_result_fifo: a reference queue and statistics model are
// advanced every cycle and every DUT output is compared against them.
module tb_posit_result_fifo;
    localparam int N     = 36;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_stats = 1'b0;
    logic full, empty, overflow;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0] drop_cnt, nar_cnt;

    posit_result_fifo_if #(.N(N)) bus ();

    posit_result_fifo #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .full(full), .empty(empty), .level(level),
        .drop_cnt(drop_cnt), .nar_cnt(nar_cnt),
        .overflow(overflow), .clr_stats(clr_stats)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [N+2:0]     sb_q [$];
    logic [CNT_W-1:0] m_drop, m_nar;
    logic             m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N+2:0] mk(input logic [N-1:0] d);
        logic z, nr, s;
        z  = (d == '0);
        nr = (d == NAR);
        s  = d[N-1] && !nr;
        return {z, nr, s, d};
    endfunction

    task automatic model_reset();
        sb_q.delete();
        m_drop = '0;
        m_nar  = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic compare_all();
        chk("valid", bus.out_valid, sb_q.size() != 0);
        chk("empty", empty, sb_q.size() == 0);
        chk("full", full, sb_q.size() == DEPTH);
        chk("level", level, sb_q.size());
        chk("drop_cnt", drop_cnt, m_drop);
        chk("nar_cnt", nar_cnt, m_nar);
        chk("overflow", overflow, m_ovf);
        if (sb_q.size() != 0) begin
            chk("data", bus.out_data, sb_q[0][N-1:0]);
            chk("sign", bus.out_sign, sb_q[0][N]);
            chk("nar", bus.out_nar, sb_q[0][N+1]);
            chk("zero", bus.out_zero, sb_q[0][N+2]);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge
    task automatic step(input logic done, input logic [N-1:0] d, input logic rdy, input logic clr);
        logic rd_m, wr_m, full_m;
        logic [N+2:0] e;
        bus.in_done   = done;
        bus.in_data   = d;
        bus.out_ready = rdy;
        clr_stats     = clr;
        e      = mk(d);
        full_m = (sb_q.size() == DEPTH);
        rd_m   = (sb_q.size() != 0) && rdy;
        wr_m   = done && (!full_m || rd_m);
        @(posedge clk);
        if (clr) begin
            m_drop = '0;
            m_nar  = '0;
            m_ovf  = 1'b0;
        end else begin
            if (done && !wr_m) begin
                if (m_drop != CMAX) m_drop = m_drop + 1'b1;
                m_ovf = 1'b1;
            end
            if (wr_m && e[N+1] && m_nar != CMAX) m_nar = m_nar + 1'b1;
        end
        if (rd_m) void'(sb_q.pop_front());
        if (wr_m) sb_q.push_back(e);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, rdy, 1'b0);
    endtask

    initial begin
        logic [63:0] t;
        logic [N-1:0] d;
        bus.in_done   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_data", bus.out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        compare_all();

        // +1.0 then drain
        step(1'b1, 36'h400000000, 1'b0, 1'b0);
        chk("one_data", bus.out_data, 36'h400000000);
        chk("one_level", level, 1);
        idle(1'b1);

        // zero then NaR
        step(1'b1, 36'h000000000, 1'b0, 1'b0);
        step(1'b1, 36'h800000000, 1'b0, 1'b0);
        chk("zero_head", bus.out_zero, 1);
        idle(1'b1);
        chk("nar_head", bus.out_nar, 1);
        chk("nar_sign", bus.out_sign, 0);
        chk("nar_cnt1", nar_cnt, 1);
        idle(1'b1);
        chk("drained", empty, 1);

        // negative value
        step(1'b1, 36'hC00000000, 1'b0, 1'b0);
        chk("neg_sign", bus.out_sign, 1);
        chk("neg_nar", bus.out_nar, 0);
        idle(1'b1);

        // overfill with consumer stalled
        for (int i = 1; i <= 10; i++) step(1'b1, N'(i), 1'b0, 1'b0);
        chk("ovf_full", full, 1);
        chk("ovf_drop", drop_cnt, 2);
        chk("ovf_sticky", overflow, 1);
        step(1'b1, 36'h0000000AA, 1'b1, 1'b0);
        chk("fullrw_level", level, 8);
        chk("fullrw_drop", drop_cnt, 2);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);

        step(1'b0, '0, 1'b0, 1'b1);
        chk("clr_drop", drop_cnt, 0);

        // async reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, N'(36'h100 + i), 1'b0, 1'b0);
        bus.in_done = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_data", bus.out_data, 0);
        chk("arst_sign", bus.out_sign, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        step(1'b1, 36'h123456789, 1'b0, 1'b0);
        step(1'b1, 36'hF00000001, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // clear coincident with a drop
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, N'(36'h200 + i), 1'b0, 1'b0);
        step(1'b1, 36'h3FF, 1'b0, 1'b1);
        chk("clrdrop_cnt", drop_cnt, 0);
        chk("clrdrop_ovf", overflow, 0);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            t = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       d = '0;
                1:       d = NAR;
                default: d = t[N-1:0];
            endcase
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0);
        end
        for (int i = 0; i < DEPTH; i++) idle(1'b1);
        step(1'b0, '0, 1'b1, 1'b1);

        // NaR stream to saturate the counter
        for (int i = 0; i < (1 << CNT_W) + 4; i++) step(1'b1, NAR, 1'b1, 1'b0);
        chk("nar_sat", nar_cnt, 16'hFFFF);
        for (int i = 0; i < 2; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/posit_result_fifo.md
Name: posit_result_fifo

Overview:
- Output stage directly downstream of posit_mul. Captures each product presented with `done`, classifies it (zero, NaR, sign), and buffers it in a first-word-fall-through FIFO.
- Presents buffered results to the next consumer over a valid/ready handshake.
- Keeps saturating statistics so a stalled consumer never back-pressures the multiplier silently.

Parameters:
- N, 36, posit word width; matches posit_mul.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  N  posit result from posit_mul (`out`).
- in_done  in  1  result-valid strobe from posit_mul (`done`); one result per cycle high.
- out_data  out  N  head-of-FIFO posit.
- out_zero  out  1  head entry is zero (all bits 0).
- out_nar  out  1  head entry is NaR (MSB 1, rest 0).
- out_sign  out  1  head entry sign (MSB); 0 when out_nar.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer accepts head this cycle.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- level  out  clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  CNT_W  results discarded due to full, saturating.
- nar_cnt  out  CNT_W  NaR results accepted, saturating.
- overflow  out  1  sticky: at least one drop since reset or clear.
- clr_stats  in  1  synchronous clear of drop_cnt, nar_cnt, overflow.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, empty=1, full=0, level=0.
  - out_data=0, out_zero=0, out_nar=0, out_sign=0.
  - drop_cnt=0, nar_cnt=0, overflow=0.
  - Read/write pointers are 0 and contents are discarded.
  - Reset mid-operation loses all buffered entries; no partial state survives.
- Classification:
  - Computed combinationally from in_data at write time.
  - Stored alongside the word, N+3 bits per entry.
  - zero = ~|in_data.
  - nar = in_data[N-1] & ~|in_data[N-2:0].
  - sign = in_data[N-1] & ~nar.
- Read: rd = out_valid & out_ready.
- Write: wr = in_done & (~full | rd).
  - When full with a simultaneous read, the write is accepted: the slot frees this edge.
- Drop: in_done & ~wr.
  - Increments drop_cnt, saturating at 2^CNT_W−1.
  - Sets overflow.
- nar_cnt increments (saturating) only on wr with nar=1. Dropped NaRs count only in drop_cnt.
- Pointers: DEPTH-modulo wrap. level += wr − rd each edge. Simultaneous wr & rd leaves level unchanged.
- FWFT output:
  - out_* reflect memory[rd_ptr] whenever level>0.
  - Latency is 1 cycle: a write at edge k gives out_valid=1 after edge k.
  - Empty-FIFO write with out_ready=1 does not bypass; the data appears the next cycle.
- out_valid == ~empty. Outputs are held stable while out_valid & ~out_ready.
- When empty, out_data, out_zero, out_nar, out_sign are don't-care-free: they hold the last-read values. The bench must not check them.
- clr_stats wins over a coincident increment: the counter goes to 0 and that event is not counted. FIFO contents and pointers are unaffected.
- full and empty are registered-equivalent. They are derived from the registered level, with no combinational path from in_done or out_ready.
- No combinational path from in_data/in_done to any output.

Test Plan:
- Reset, then write 36'h400000000 (+1.0) with out_ready=0 → next cycle out_valid=1, out_data=36'h400000000, out_zero=0, out_nar=0, out_sign=0, level=1.
- Write 36'h000000000 then 36'h800000000, then read both → first beat out_zero=1; second beat out_nar=1, out_sign=0; nar_cnt=1; empty=1 after.
- Write 36'hC00000000 → out_sign=1, out_nar=0.
- out_ready=0, in_done high for 10 cycles (DEPTH=8) → full=1 after 8 writes; drop_cnt=2; overflow=1; entries 1–8 read back in order.
- Full FIFO with in_done=1 and out_ready=1 the same cycle → write accepted, drop_cnt unchanged, level stays 8.
- Fill with 3 entries, assert rst mid-stream → outputs 0 immediately (async), level=0; after release, new data flows normally.
- Stream ≥2^CNT_W NaRs with out_ready=1 → nar_cnt saturates at 16'hFFFF. clr_stats coincident with a drop → drop_cnt=0 and overflow=0 next cycle.
